uart2sample: RTL and testbench

- Writer side of the sample FIFO.
- Takes bytes from the UART receiver, pairs them into 16-bit samples (low byte first), and pushes each sample into fifo_buffor.
- sample_switch drains the same FIFO on the other side.
- Active only while the global mode is UART (2'b01); idle in every other mode.

---
 rtl/sample_pkg.sv | 19 +
 rtl/sat_counter.sv | 25 ++
 rtl/uart2sample.sv | 118 +++++++++++
 tb/tb_uart2sample.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - shared mode constants, writer FSM encoding and sample width
package sample_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] MODE_IDLE       = 2'b00;
  localparam logic [1:0] MODE_UART       = 2'b01;
  localparam logic [1:0] MODE_I2S_2HZ    = 2'b10;
  localparam logic [1:0] MODE_I2S_441kHZ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOW  = 3'd1,
    S_WAIT_HIGH = 3'd2,
    S_WRITE     = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_inc,
  output logic [W-1:0] out_count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;

endmodule

// File: rtl/uart2sample.sv
// rtl/uart2sample.sv - pairs UART bytes (low first) into 16-bit samples for the sample FIFO
module uart2sample
  import sample_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic [1:0]          in_mode,
  input  logic [7:0]          in_byte,
  input  logic                in_byte_valid,
  input  logic                in_fifo_full,
  output logic [SAMPLE_W-1:0] out_fifo_sample,
  output logic                out_fifo_wr_en,
  output logic [CNT_W-1:0]    out_overflow_cnt,
  output logic [CNT_W-1:0]    out_timeout_cnt,
  output logic                out_busy
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [7:0]          low_q;
  logic [SAMPLE_W-1:0] hold_q;
  logic [SAMPLE_W-1:0] last_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                parity_q;

  logic mode_uart, tmo_expired, absorb, load_low, pair_done;
  logic ovf_inc, tmo_inc;

  assign mode_uart   = (in_mode == MODE_UART);
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Bytes swallowed while a sample is stuck, or the leftover high byte of a
  // half-received dropped pair; parity keeps the byte framing aligned.
  assign absorb = mode_uart && in_byte_valid &&
                  ((((state_q == S_WRITE) || (state_q == S_HOLD)) && in_fifo_full) ||
                   (parity_q && ((state_q == S_HOLD) || (state_q == S_WAIT_LOW))));

  always_comb begin
    state_d = state_q;
    if (!mode_uart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_WAIT_LOW;
        S_WAIT_LOW:  if (in_byte_valid && !parity_q) state_d = S_WAIT_HIGH;
        S_WAIT_HIGH: begin
          if (in_byte_valid)    state_d = S_WRITE;
          else if (tmo_expired) state_d = S_WAIT_LOW;
        end
        S_WRITE: begin
          if (in_fifo_full)       state_d = S_HOLD;
          else if (in_byte_valid) state_d = S_WAIT_HIGH;
          else                    state_d = S_WAIT_LOW;
        end
        S_HOLD: begin
          if (!in_fifo_full)
            state_d = (in_byte_valid && !parity_q) ? S_WAIT_HIGH : S_WAIT_LOW;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_fifo_wr_en = mode_uart && !in_fifo_full &&
                     ((state_q == S_WRITE) || (state_q == S_HOLD));
    out_busy       = (state_q == S_WAIT_HIGH) || (state_q == S_WRITE) || (state_q == S_HOLD);
    ovf_inc        = absorb && parity_q;
    tmo_inc        = mode_uart && (state_q == S_WAIT_HIGH) && !in_byte_valid && tmo_expired;
    load_low       = mode_uart && in_byte_valid &&
                     (state_d == S_WAIT_HIGH) && (state_q != S_WAIT_HIGH);
    pair_done      = (state_q == S_WAIT_HIGH) && (state_d == S_WRITE);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      low_q    <= '0;
      hold_q   <= '0;
      last_q   <= '0;
      tmo_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_low) begin
        low_q <= in_byte;
        tmo_q <= '0;
      end else if (state_q == S_WAIT_HIGH) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (pair_done)      hold_q <= {in_byte, low_q};
      if (out_fifo_wr_en) last_q <= hold_q;
      if (!mode_uart)     parity_q <= 1'b0;
      else if (absorb)    parity_q <= ~parity_q;
    end
  end

  assign out_fifo_sample = out_fifo_wr_en ? hold_q : last_q;

  sat_counter #(.W(CNT_W)) u_overflow_cnt (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_inc    (ovf_inc),
    .out_count (out_overflow_cnt)
  );

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_inc    (tmo_inc),
    .out_count (out_timeout_cnt)
  );

endmodule

// File: tb/tb_uart2sample.sv
// tb/tb_uart2sample.sv - directed self-checking bench for uart2sample
module tb_uart2sample;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  byte_in;
  logic        valid;
  logic        full;
  logic [15:0] sample;
  logic        wr_en;
  logic [1:0]  ovf_cnt;
  logic [1:0]  tmo_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_while_full = 0;

  always #5 clk = ~clk;

  uart2sample #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_mode          (mode),
    .in_byte          (byte_in),
    .in_byte_valid    (valid),
    .in_fifo_full     (full),
    .out_fifo_sample  (sample),
    .out_fifo_wr_en   (wr_en),
    .out_overflow_cnt (ovf_cnt),
    .out_timeout_cnt  (tmo_cnt),
    .out_busy         (busy)
  );

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt = wr_cnt + 1;
      if (full) wr_while_full = wr_while_full + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; byte_in = 8'h00; valid = 1'b0; full = 1'b0;
    tick(); tick();
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_sample", sample, 16'h0000);
    chk("reset_ovf", ovf_cnt, 2'd0);
    chk("reset_tmo", tmo_cnt, 2'd0);
    chk("reset_busy", busy, 1'b0);

    rst = 1'b0; mode = 2'b01;
    tick();

    // reset in the middle of a sample
    send(8'h34);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_no_wr", wr_cnt, 0);
    tick();
    send(8'h12);
    chk("mid_no_wr_low", wr_cnt, 0);
    send(8'h56);
    chk("mid_wr_en", wr_en, 1'b1);
    chk("mid_sample", sample, 16'h5612);
    tick();
    chk("mid_wr_cnt", wr_cnt, 1);

    // basic pairing, write one cycle after the high byte
    send(8'h34);
    send(8'h12);
    chk("basic_wr_en", wr_en, 1'b1);
    chk("basic_sample", sample, 16'h1234);
    tick();
    chk("basic_wr_en_drop", wr_en, 1'b0);
    chk("basic_sample_hold", sample, 16'h1234);
    chk("basic_wr_cnt", wr_cnt, 2);
    chk("basic_busy", busy, 1'b0);

    // full FIFO hold with an overflow pair
    full = 1'b1;
    send(8'hCD);
    send(8'hAB);
    chk("hold_no_wr", wr_en, 1'b0);
    repeat (5) tick();
    send(8'h01);
    send(8'h02);
    repeat (13) tick();
    chk("hold_ovf", ovf_cnt, 2'd1);
    chk("hold_wr_cnt", wr_cnt, 2);
    chk("hold_busy", busy, 1'b1);
    full = 1'b0;
    #1;
    chk("release_wr_en", wr_en, 1'b1);
    chk("release_sample", sample, 16'hABCD);
    tick();
    chk("release_wr_cnt", wr_cnt, 3);
    send(8'h11);
    send(8'h22);
    chk("after_hold_sample", sample, 16'h2211);
    chk("after_hold_wr_en", wr_en, 1'b1);
    tick();
    chk("after_hold_wr_cnt", wr_cnt, 4);

    // timeout discards the low byte
    send(8'h55);
    repeat (16) tick();
    chk("tmo_cnt", tmo_cnt, 2'd1);
    chk("tmo_busy", busy, 1'b0);
    send(8'h66);
    send(8'h77);
    chk("tmo_sample", sample, 16'h7766);
    tick();
    chk("tmo_wr_cnt", wr_cnt, 5);

    // byte on the expiry cycle wins
    send(8'h99);
    repeat (15) tick();
    send(8'h88);
    chk("tmo_edge_sample", sample, 16'h8899);
    chk("tmo_edge_cnt", tmo_cnt, 2'd1);
    tick();
    chk("tmo_edge_wr_cnt", wr_cnt, 6);

    // mode exit mid-sample
    send(8'h10);
    chk("mode_busy", busy, 1'b1);
    mode = 2'b10;
    tick();
    chk("mode_exit_busy", busy, 1'b0);
    chk("mode_exit_wr_en", wr_en, 1'b0);
    send(8'h20);
    chk("mode_exit_ignore", busy, 1'b0);
    mode = 2'b01;
    tick();
    send(8'h01);
    send(8'h02);
    chk("mode_reentry_sample", sample, 16'h0201);
    tick();
    chk("mode_wr_cnt", wr_cnt, 7);
    chk("mode_ovf_kept", ovf_cnt, 2'd1);

    // overflow counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("sat_reset_ovf", ovf_cnt, 2'd0);
    full = 1'b1;
    send(8'hA1);
    send(8'hA2);
    for (int i = 0; i < 5; i++) begin
      send(8'(i));
      send(8'(i + 8'h40));
    end
    chk("sat_ovf", ovf_cnt, 2'd3);
    full = 1'b0;
    #1;
    chk("sat_release_sample", sample, 16'hA2A1);
    tick();
    chk("sat_wr_cnt", wr_cnt, 8);
    chk("never_wr_while_full", wr_while_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
